// File: rtl/uart_bus_master_if.sv
// Register-bus connection between the UART bus master and the UART register slave.
interface uart_bus_master_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (
    output cs, read, write, addr, wr_data,
    input  rd_data
  );

  modport slave (
    input  cs, read, write, addr, wr_data,
    output rd_data
  );
endinterface

// File: rtl/uart_bus_master.sv
// UART bus master: programs the baud divisor, then polls the UART register
// slave and moves bytes between the slave and a one-entry transmit buffer /
// one-entry receive output register, alternating fairly between rx and tx.
module uart_bus_master #(
  parameter logic [10:0] DVSR_INIT = 11'd325
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_bus_master_if.master        bus,
  input  logic [7:0]               tx_data,
  input  logic                     tx_valid,
  output logic                     tx_ready,
  output logic [7:0]               rx_data,
  output logic                     rx_valid,
  input  logic                     rx_ready,
  input  logic [10:0]              dvsr_in,
  input  logic                     dvsr_load,
  output logic                     busy
);

  // Slave register map.
  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_DVSR   = 5'd1;
  localparam logic [4:0] ADDR_TX     = 5'd2;
  localparam logic [4:0] ADDR_POP    = 5'd3;

  typedef enum logic [2:0] {
    INIT,
    POLL,
    DECIDE,
    POP,
    TX
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        boot_done;

  // Status snapshot taken at the end of each POLL cycle.
  logic        st_tx_full;
  logic        st_rx_empty;
  logic [7:0]  st_r_data;

  // Fairness: 0 favours rx, 1 favours tx when both are ready.
  logic        fair;

  logic [7:0]  tx_buf;
  logic        tx_buf_full;

  logic [10:0] divisor;
  logic        pending;

  logic        rx_cand;
  logic        tx_cand;

  // Status bits [31:10] carry nothing the master uses.
  logic        unused_status_bits;
  assign unused_status_bits = ^bus.rd_data[31:10];

  assign tx_ready = ~tx_buf_full;
  assign busy     = (state == INIT) | pending;

  assign rx_cand  = ~st_rx_empty & ~rx_valid;
  assign tx_cand  = tx_buf_full & ~st_tx_full;

  // Next-state selection: divisor request beats traffic, then fair rx/tx choice.
  always_comb begin
    next_state = POLL;
    unique case (state)
      INIT:   next_state = POLL;
      POLL:   next_state = DECIDE;
      DECIDE: begin
        if (pending)
          next_state = INIT;
        else if (rx_cand && tx_cand)
          next_state = fair ? TX : POP;
        else if (rx_cand)
          next_state = POP;
        else if (tx_cand)
          next_state = TX;
        else
          next_state = POLL;
      end
      POP:    next_state = POLL;
      TX:     next_state = POLL;
    endcase
    // The reset state is INIT with an idle bus; the first edge after release
    // presents the INIT write, so INIT is re-entered once before advancing.
    if (!boot_done)
      next_state = INIT;
  end

  // FSM with bus strobes registered from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      boot_done   <= 1'b0;
      st_tx_full  <= 1'b0;
      st_rx_empty <= 1'b1;
      st_r_data   <= '0;
      fair        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      bus.cs      <= 1'b0;
      bus.read    <= 1'b0;
      bus.write   <= 1'b0;
      bus.addr    <= '0;
      bus.wr_data <= '0;
    end else begin
      boot_done <= 1'b1;
      state     <= next_state;

      if (state == POLL) begin
        st_tx_full  <= bus.rd_data[9];
        st_rx_empty <= bus.rd_data[8];
        st_r_data   <= bus.rd_data[7:0];
      end

      if (next_state == POP || next_state == TX)
        fair <= ~fair;

      if (next_state == POP) begin
        rx_data  <= st_r_data;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      bus.cs      <= 1'b0;
      bus.read    <= 1'b0;
      bus.write   <= 1'b0;
      bus.addr    <= '0;
      bus.wr_data <= '0;
      unique case (next_state)
        INIT: begin
          bus.cs      <= 1'b1;
          bus.write   <= 1'b1;
          bus.addr    <= ADDR_DVSR;
          bus.wr_data <= {21'b0, divisor};
        end
        POLL: begin
          bus.cs   <= 1'b1;
          bus.read <= 1'b1;
          bus.addr <= ADDR_STATUS;
        end
        DECIDE: ;
        POP: begin
          bus.cs    <= 1'b1;
          bus.write <= 1'b1;
          bus.addr  <= ADDR_POP;
        end
        TX: begin
          bus.cs      <= 1'b1;
          bus.write   <= 1'b1;
          bus.addr    <= ADDR_TX;
          bus.wr_data <= {24'b0, tx_buf};
        end
      endcase
    end
  end

  // One-entry transmit buffer; loads only while empty, so never races the TX clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_buf      <= '0;
      tx_buf_full <= 1'b0;
    end else if (next_state == TX) begin
      tx_buf_full <= 1'b0;
    end else if (tx_valid && tx_ready) begin
      tx_buf      <= tx_data;
      tx_buf_full <= 1'b1;
    end
  end

  // Divisor request latch; a new request wins over the clear so it is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divisor <= DVSR_INIT;
      pending <= 1'b0;
    end else if (dvsr_load) begin
      divisor <= dvsr_in;
      pending <= 1'b1;
    end else if (next_state == INIT) begin
      pending <= 1'b0;
    end
  end

endmodule
